audio_output_fifo: RTL and testbench
====================================

# audio_output_fifo

Stereo frame buffer between the audio output mux and the PCM-to-I2S serializer. Pairs independently strobed left/right 24-bit samples into frames, buffers them in a small FIFO, and hands one frame to the serializer per request. Absorbs burst/jitter differences between the processing pipeline's sample strobes and the serializer's fixed frame rate. Reports overflow, underrun and pairing errors to CPU status.

## Interface
- DEPTH_LOG2, 4, FIFO depth is 2^DEPTH_LOG2 stereo frames.
- DATA_W, 24, sample width per channel.
- PRIME_LEVEL, 8, fill level (frames) required before streaming starts; must be 1..2^DEPTH_LOG2.
- clk  in  1  system clock; single clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- run  in  1  audio enable (audio_control[0]); low flushes the block.
- l_din_en  in  1  left sample strobe, 1-cycle pulse.
- r_din_en  in  1  right sample strobe, 1-cycle pulse.
- l_din  in  DATA_W  left sample, valid with l_din_en.
- r_din  in  DATA_W  right sample, valid with r_din_en.
- frame_req  in  1  serializer request for next frame, 1-cycle pulse.
- dout_valid  out  1  1-cycle pulse answering frame_req.
- l_dout  out  DATA_W  left output sample, held between pulses.
- r_dout  out  DATA_W  right output sample, held between pulses.
- fifo_level  out  DEPTH_LOG2+1  frames currently stored.
- streaming  out  1  high in STREAM state.
- overflow  out  1  sticky: frame dropped because FIFO full.
- underrun  out  1  sticky: frame_req in STREAM with FIFO empty.
- pair_err  out  1  sticky: left/right strobe ordering violated.
- status_clr  in  1  clears the three sticky flags (pulse).

## Operation
- Pairing: l_din_en loads left staging register, sets left_pending. r_din_en with left_pending writes frame {left, r_din}, clears left_pending. Simultaneous l_din_en and r_din_en write {l_din, r_din} directly. l_din_en while left_pending: overwrite staging, set pair_err. r_din_en without left_pending: discard, set pair_err.
- Write: if level == 2^DEPTH_LOG2 and no read same cycle, frame dropped, overflow set. Full with read same cycle: write accepted, level unchanged.
- States: IDLE (run low), PRIME, STREAM. IDLE -> PRIME when run high. PRIME -> STREAM when level >= PRIME_LEVEL. STREAM -> PRIME on underrun. Any state -> IDLE when run low.
- Read: frame_req in STREAM with level > 0 pops head frame. frame_req in PRIME or on underrun outputs fill frame (see Configuration); no pop. frame_req in IDLE ignored, no dout_valid.
- Empty FIFO with write and frame_req same cycle: no bypass; treated as underrun, write still stored.
- run low: pointers, level, left_pending cleared next cycle; sticky flags retained; l_dout/r_dout zeroed.
- status_clr has priority below a same-cycle set (set wins).
- Pointers wrap modulo 2^DEPTH_LOG2; level saturates at neither end by construction.

## Timing
- Reset: all outputs 0, state IDLE, pointers 0.
- Write latency: frame counted in fifo_level the cycle after the completing strobe.
- Read latency: dout_valid and new l_dout/r_dout exactly 1 cycle after frame_req.
- PRIME -> STREAM transition visible on streaming 1 cycle after level reaches PRIME_LEVEL.
- Sticky flags assert 1 cycle after the causing event.

## Configuration
- AUDIO_FIFO_MUTE_ON_UNDERRUN_EN defined: fill frame is zeros (mute) in PRIME and on underrun.
- Not defined: fill frame repeats last frame output (zeros if none since run rose).

## Structure
- Package audio_fifo_pkg: state enum (IDLE, PRIME, STREAM), default DATA_W, frame width constant 2*DATA_W.
- Sub-module stereo_frame_ram: simple dual-port 2*DATA_W x 2^DEPTH_LOG2 memory, synchronous write, registered read.

## Test plan
- Reset then run high, 8 L/R pairs (L=0x100000+n, R=0x200000+n) -> streaming rises after 8th frame; 8 frame_req pulses return pairs in order, 1-cycle latency.
- 17 frames with no reads (depth 16) -> fifo_level 16, overflow=1, 17th frame absent on readback.
- Stream active, level 0, frame_req -> underrun=1, streaming=0, output 0x000000/0x000000 with macro, last frame repeated without.
- Two l_din_en without r_din_en, then r_din_en -> pair_err=1, stored frame uses second left value.
- run dropped mid-stream with 5 frames stored -> level 0, l_dout/r_dout 0, flags retained; status_clr -> flags 0.

Source files
------------

// File: rtl/audio_fifo_pkg.sv
// rtl/audio_fifo_pkg.sv - shared state encoding and widths for the audio output FIFO
package audio_fifo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PRIME  = 2'd1,
        ST_STREAM = 2'd2
    } fifo_state_t;

    localparam int AUDIO_DATA_W  = 24;
    localparam int AUDIO_FRAME_W = 2 * AUDIO_DATA_W;

    function automatic int frame_width(input int data_w);
        return 2 * data_w;
    endfunction

endpackage

// File: rtl/stereo_frame_ram.sv
// rtl/stereo_frame_ram.sv - simple dual-port frame store, synchronous write, registered read
module stereo_frame_ram
    import audio_fifo_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = AUDIO_FRAME_W
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    // Read-during-write to the same address returns the old word, which the
    // full-FIFO simultaneous read/write case relies on.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/audio_output_fifo.sv
// rtl/audio_output_fifo.sv - pairs L/R strobes into frames and buffers them for the I2S serializer
// Optional: AUDIO_FIFO_MUTE_ON_UNDERRUN_EN selects a zero fill frame instead of repeating the last frame.
module audio_output_fifo
    import audio_fifo_pkg::*;
#(
    parameter int DEPTH_LOG2  = 4,
    parameter int DATA_W      = AUDIO_DATA_W,
    parameter int PRIME_LEVEL = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  run,
    input  logic                  l_din_en,
    input  logic                  r_din_en,
    input  logic [DATA_W-1:0]     l_din,
    input  logic [DATA_W-1:0]     r_din,
    input  logic                  frame_req,
    output logic                  dout_valid,
    output logic [DATA_W-1:0]     l_dout,
    output logic [DATA_W-1:0]     r_dout,
    output logic [DEPTH_LOG2:0]   fifo_level,
    output logic                  streaming,
    output logic                  overflow,
    output logic                  underrun,
    output logic                  pair_err,
    input  logic                  status_clr
);

    localparam int FW = frame_width(DATA_W);
    localparam logic [DEPTH_LOG2:0] FULL_LVL  = (DEPTH_LOG2+1)'(1 << DEPTH_LOG2);
    localparam logic [DEPTH_LOG2:0] PRIME_LVL = (DEPTH_LOG2+1)'(PRIME_LEVEL);

    fifo_state_t state, state_next;

    logic [DATA_W-1:0]     left_stage, stage_next;
    logic                  left_pending, pend_next;
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [DEPTH_LOG2:0]   level;

    logic          pair_wr, pair_evt;
    logic [FW-1:0] pair_frame;
    logic          wr_ok, overflow_evt;
    logic          pop, fill, underrun_evt;

    logic [FW-1:0] rd_data;
    logic          pop_q;
    logic [FW-1:0] hold_frame;
    logic [FW-1:0] out_frame;
    logic [FW-1:0] fill_frame;

    // Strobe pairing: left stages, right completes; ordering slips are flagged.
    always_comb begin
        pair_wr    = 1'b0;
        pair_evt   = 1'b0;
        pair_frame = {left_stage, r_din};
        pend_next  = left_pending;
        stage_next = left_stage;
        if (!run) begin
            pend_next  = 1'b0;
            stage_next = '0;
        end else if (l_din_en && r_din_en) begin
            pair_wr    = 1'b1;
            pair_frame = {l_din, r_din};
            pend_next  = 1'b0;
        end else if (l_din_en) begin
            pair_evt   = left_pending;
            stage_next = l_din;
            pend_next  = 1'b1;
        end else if (r_din_en) begin
            if (left_pending) begin
                pair_wr   = 1'b1;
                pend_next = 1'b0;
            end else begin
                pair_evt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        pop          = 1'b0;
        fill         = 1'b0;
        underrun_evt = 1'b0;
        case (state)
            ST_IDLE: begin
                if (run) state_next = ST_PRIME;
            end
            ST_PRIME: begin
                fill = frame_req;
                if (level >= PRIME_LVL) state_next = ST_STREAM;
            end
            ST_STREAM: begin
                if (frame_req) begin
                    if (level != '0) begin
                        pop = 1'b1;
                    end else begin
                        fill         = 1'b1;
                        underrun_evt = 1'b1;
                        state_next   = ST_PRIME;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
        if (!run) begin
            state_next   = ST_IDLE;
            pop          = 1'b0;
            fill         = 1'b0;
            underrun_evt = 1'b0;
        end
    end

    // A full FIFO still accepts a frame when the head leaves in the same cycle.
    assign wr_ok        = pair_wr && ((level != FULL_LVL) || pop);
    assign overflow_evt = pair_wr && !wr_ok;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            left_stage   <= '0;
            left_pending <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
        end else begin
            left_stage   <= stage_next;
            left_pending <= pend_next;
            if (!run) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                level  <= '0;
            end else begin
                if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
                if (pop)   rd_ptr <= rd_ptr + 1'b1;
                case ({wr_ok, pop})
                    2'b10:   level <= level + 1'b1;
                    2'b01:   level <= level - 1'b1;
                    default: level <= level;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
            underrun <= 1'b0;
            pair_err <= 1'b0;
        end else begin
            overflow <= overflow_evt | (overflow & ~status_clr);
            underrun <= underrun_evt | (underrun & ~status_clr);
            pair_err <= pair_evt     | (pair_err & ~status_clr);
        end
    end

    stereo_frame_ram #(
        .ADDR_W (DEPTH_LOG2),
        .DATA_W (FW)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_ok),
        .wr_addr (wr_ptr),
        .wr_data (pair_frame),
        .rd_en   (pop),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

    // The RAM output is live only the cycle after a pop; hold_frame keeps it afterwards.
    assign out_frame = pop_q ? rd_data : hold_frame;

`ifdef AUDIO_FIFO_MUTE_ON_UNDERRUN_EN
    assign fill_frame = '0;
`else
    assign fill_frame = out_frame;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pop_q      <= 1'b0;
            hold_frame <= '0;
            dout_valid <= 1'b0;
        end else if (!run) begin
            pop_q      <= 1'b0;
            hold_frame <= '0;
            dout_valid <= 1'b0;
        end else begin
            pop_q      <= pop;
            dout_valid <= pop | fill;
            if (fill) begin
                hold_frame <= fill_frame;
            end else if (pop_q) begin
                hold_frame <= rd_data;
            end
        end
    end

    assign l_dout     = out_frame[FW-1:DATA_W];
    assign r_dout     = out_frame[DATA_W-1:0];
    assign fifo_level = level;
    assign streaming  = (state == ST_STREAM);

endmodule

// File: tb/tb_audio_output_fifo.sv
// tb/tb_audio_output_fifo.sv - directed scoreboard bench for audio_output_fifo
module tb_audio_output_fifo;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        run;
    logic        l_din_en, r_din_en;
    logic [23:0] l_din, r_din;
    logic        frame_req;
    logic        dout_valid;
    logic [23:0] l_dout, r_dout;
    logic [4:0]  fifo_level;
    logic        streaming, overflow, underrun, pair_err;
    logic        status_clr;

    int checks = 0;
    int fails  = 0;
    int model_level = 0;
    logic [47:0] sb[$];
    logic [47:0] last_out;

    always #5 clk = ~clk;

    audio_output_fifo #(
        .DEPTH_LOG2  (4),
        .DATA_W      (24),
        .PRIME_LEVEL (8)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .run        (run),
        .l_din_en   (l_din_en),
        .r_din_en   (r_din_en),
        .l_din      (l_din),
        .r_din      (r_din),
        .frame_req  (frame_req),
        .dout_valid (dout_valid),
        .l_dout     (l_dout),
        .r_dout     (r_dout),
        .fifo_level (fifo_level),
        .streaming  (streaming),
        .overflow   (overflow),
        .underrun   (underrun),
        .pair_err   (pair_err),
        .status_clr (status_clr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_pair(input logic [23:0] l, input logic [23:0] r);
        l_din_en = 1'b1; l_din = l;
        tick();
        l_din_en = 1'b0; r_din_en = 1'b1; r_din = r;
        tick();
        r_din_en = 1'b0;
        if (model_level < 16) begin
            sb.push_back({l, r});
            model_level++;
        end
    endtask

    task automatic req_pop(input string tag);
        logic [47:0] exp;
        frame_req = 1'b1;
        tick();
        frame_req = 1'b0;
        exp = (sb.size() > 0) ? sb.pop_front() : 48'h0;
        if (model_level > 0) model_level--;
        check({tag, "_valid"}, dout_valid, 1);
        check(tag, {l_dout, r_dout}, exp);
        last_out = exp;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; run = 1'b0; l_din_en = 1'b0; r_din_en = 1'b0;
        l_din = '0; r_din = '0; frame_req = 1'b0; status_clr = 1'b0;
        last_out = '0;
        repeat (3) tick();
        check("rst_level", fifo_level, 0);
        check("rst_stream", streaming, 0);
        check("rst_valid", dout_valid, 0);
        check("rst_dout", {l_dout, r_dout}, 0);
        check("rst_flags", {overflow, underrun, pair_err}, 0);
        reset_n = 1'b1;
        tick();

        // Priming and ordered streaming
        run = 1'b1;
        tick();
        for (int n = 0; n < 7; n++) send_pair(24'h100000 + n, 24'h200000 + n);
        check("prime_level7", fifo_level, 7);
        check("prime_stream7", streaming, 0);
        send_pair(24'h100007, 24'h200007);
        check("prime_level8", fifo_level, 8);
        check("prime_stream_lag", streaming, 0);
        tick();
        check("stream_up", streaming, 1);
        for (int n = 0; n < 8; n++) req_pop("pop1");
        tick();
        check("valid_pulse", dout_valid, 0);
        check("drained_level", fifo_level, 0);

        // Underrun in STREAM
        frame_req = 1'b1;
        tick();
        frame_req = 1'b0;
        check("ur_valid", dout_valid, 1);
        check("ur_flag", underrun, 1);
        check("ur_stream", streaming, 0);
`ifdef AUDIO_FIFO_MUTE_ON_UNDERRUN_EN
        check("ur_fill", {l_dout, r_dout}, 48'h0);
`else
        check("ur_fill", {l_dout, r_dout}, {24'h100007, 24'h200007});
`endif

        // Fill to full, then overflow
        for (int n = 0; n < 16; n++) send_pair(24'h300000 + n, 24'h400000 + n);
        check("full_level", fifo_level, 16);
        check("full_no_ovf", overflow, 0);
        send_pair(24'h3000AA, 24'h4000AA);
        check("ovf_flag", overflow, 1);
        check("ovf_level", fifo_level, 16);

        // Full with same-cycle read: write accepted, level unchanged
        l_din_en = 1'b1; l_din = 24'h5A0001;
        tick();
        l_din_en = 1'b0; r_din_en = 1'b1; r_din = 24'h5B0001; frame_req = 1'b1;
        tick();
        r_din_en = 1'b0; frame_req = 1'b0;
        check("fullrw_valid", dout_valid, 1);
        check("fullrw_data", {l_dout, r_dout}, sb.pop_front());
        sb.push_back({24'h5A0001, 24'h5B0001});
        check("fullrw_level", fifo_level, 16);
        for (int n = 0; n < 16; n++) req_pop("pop2");
        check("pop2_level", fifo_level, 0);

        // Pairing error: second left overwrites staging
        l_din_en = 1'b1; l_din = 24'h111111;
        tick();
        l_din = 24'h222222;
        tick();
        l_din_en = 1'b0;
        check("pair_err", pair_err, 1);
        r_din_en = 1'b1; r_din = 24'h333333;
        tick();
        r_din_en = 1'b0;
        sb.push_back({24'h222222, 24'h333333});
        model_level++;
        check("pair_level", fifo_level, 1);
        req_pop("pair_frame");

        // run drop flushes, flags survive, status_clr clears them
        for (int n = 0; n < 5; n++) send_pair(24'h600000 + n, 24'h700000 + n);
        check("pre_flush_level", fifo_level, 5);
        run = 1'b0;
        tick();
        sb.delete();
        model_level = 0;
        check("flush_level", fifo_level, 0);
        check("flush_dout", {l_dout, r_dout}, 0);
        check("flush_stream", streaming, 0);
        check("flush_flags", {overflow, underrun, pair_err}, 3'b111);
        frame_req = 1'b1;
        tick();
        frame_req = 1'b0;
        check("idle_req", dout_valid, 0);
        status_clr = 1'b1;
        tick();
        status_clr = 1'b0;
        check("clr_flags", {overflow, underrun, pair_err}, 0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
